// File: rtl/ofdm_pkg.sv
// Shared OFDM receive-chain definitions: map-type encodings and symbol geometry lookups.
// Geometry comes from the 2-bit map type alone; blocks using it have no parameters.
package ofdm_pkg;

    localparam logic [1:0] MAP_BPSK  = 2'b00;
    localparam logic [1:0] MAP_QPSK  = 2'b01;
    localparam logic [1:0] MAP_16QAM = 2'b10;
    localparam logic [1:0] MAP_64QAM = 2'b11;

    localparam int NCBPS_MAX = 288;
    localparam int J_W       = 9;
    localparam int SEG_W     = 5;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } deintv2_state_t;

    // Coded bits per OFDM symbol
    function automatic logic [J_W-1:0] f_ncbps(input logic [1:0] map_type);
        logic [J_W-1:0] n;
        case (map_type)
            MAP_BPSK:  n = 9'd48;
            MAP_QPSK:  n = 9'd96;
            MAP_16QAM: n = 9'd192;
            MAP_64QAM: n = 9'd288;
            default:   n = 9'd48;
        endcase
        return n;
    endfunction

    // Segment length Ncbps/16
    function automatic logic [SEG_W-1:0] f_seg_len(input logic [1:0] map_type);
        logic [SEG_W-1:0] l;
        case (map_type)
            MAP_BPSK:  l = 5'd3;
            MAP_QPSK:  l = 5'd6;
            MAP_16QAM: l = 5'd12;
            MAP_64QAM: l = 5'd18;
            default:   l = 5'd3;
        endcase
        return l;
    endfunction

    // Group size s = max(Nbpsc/2, 1)
    function automatic logic [1:0] f_s(input logic [1:0] map_type);
        logic [1:0] s;
        case (map_type)
            MAP_BPSK:  s = 2'd1;
            MAP_QPSK:  s = 2'd1;
            MAP_16QAM: s = 2'd2;
            MAP_64QAM: s = 2'd3;
            default:   s = 2'd1;
        endcase
        return s;
    endfunction

    // (m - r) mod s, valid for m < s and r < s
    function automatic logic [1:0] f_perm_idx(input logic [1:0] m,
                                              input logic [1:0] r,
                                              input logic [1:0] s);
        logic [2:0] t;
        t = {1'b0, m} + {1'b0, s} - {1'b0, r};
        if (t >= {1'b0, s}) begin
            t = t - {1'b0, s};
        end
        return t[1:0];
    endfunction

endpackage

// File: rtl/deinterleaver_2_cnt.sv
// Wrapping up-counter with a run-time terminal value; cnt_last flags the final count.
module deinterleaver_2_cnt #(
    parameter int CNT_NUM = 288,
    parameter int CNT_W   = $clog2(CNT_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt_max,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_last
);

    assign cnt_last = (cnt == cnt_max);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/deinterleaver_2.sv
// Second-level OFDM deinterleaver: collects s-bit groups and emits them with the
// intra-group rotation undone, serial bit in and out with valid/ready on both sides.
//
//   state   | meaning
//   S_FILL  | accepting bits of the current group into bit_buf
//   S_DRAIN | presenting the rotated group on dout, one bit per dout handshake
module deinterleaver_2
    import ofdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       deintv2_din,
    input  logic       deintv2_din_vld,
    output logic       deintv2_din_rdy,
    input  logic       deintv2_din_sig_flag,
    input  logic [1:0] deintv2_din_Map_Type,
    output logic       deintv2_dout,
    output logic       deintv2_dout_vld,
    input  logic       deintv2_dout_rdy,
    output logic [1:0] deintv2_dout_Map_Type
);

    deintv2_state_t   state;
    deintv2_state_t   state_nxt;

    logic             din_acc;
    logic             dout_acc;
    logic [1:0]       map_in;
    logic [1:0]       map_lat;
    logic [1:0]       map_cur;
    logic [1:0]       s_cur;
    logic [1:0]       s_grp;
    logic [SEG_W-1:0] len_cur;
    logic [J_W-1:0]   j;
    logic [J_W-1:0]   j_max;
    logic             j_first;
    logic             j_last;
    logic [SEG_W-1:0] seg_cnt;
    logic [1:0]       r;
    logic [1:0]       g;
    logic [1:0]       m;
    logic [1:0]       group_r;
    logic [2:0]       bit_buf;
    logic [2:0]       buf_nxt;
    logic             fill_done;
    logic             drain_done;
    logic             dout_q;
    logic             dout_vld_q;

    assign deintv2_din_rdy       = (state == S_FILL);
    assign deintv2_dout          = dout_q;
    assign deintv2_dout_vld      = dout_vld_q;
    assign deintv2_dout_Map_Type = map_lat;

    assign din_acc  = deintv2_din_vld & deintv2_din_rdy;
    assign dout_acc = dout_vld_q & deintv2_dout_rdy;

    // The first bit of a symbol must already see the new geometry, so bypass the latch at j==0.
    assign map_in  = deintv2_din_sig_flag ? MAP_BPSK : deintv2_din_Map_Type;
    assign j_first = (j == '0);
    assign map_cur = j_first ? map_in : map_lat;
    assign s_cur   = f_s(map_cur);
    assign len_cur = f_seg_len(map_cur);
    assign j_max   = f_ncbps(map_cur) - 9'd1;
    assign s_grp   = f_s(map_lat);

    assign fill_done  = din_acc && (g == s_cur - 2'd1);
    assign drain_done = dout_acc && (m == s_grp - 2'd1);

    deinterleaver_2_cnt #(
        .CNT_NUM (NCBPS_MAX),
        .CNT_W   (J_W)
    ) u_j_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (din_acc),
        .cnt_max  (j_max),
        .cnt      (j),
        .cnt_last (j_last)
    );

    always_comb begin
        buf_nxt    = bit_buf;
        buf_nxt[g] = deintv2_din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL:  if (fill_done)  state_nxt = S_DRAIN;
            S_DRAIN: if (drain_done) state_nxt = S_FILL;
            default: state_nxt = S_FILL;
        endcase
    end

    // Input side: geometry latch, segment/rotation tracking and group buffer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            map_lat <= MAP_BPSK;
            seg_cnt <= '0;
            r       <= '0;
            g       <= '0;
            group_r <= '0;
            bit_buf <= '0;
        end else if (din_acc) begin
            bit_buf <= buf_nxt;
            if (j_first) begin
                map_lat <= map_in;
            end
            if (j_last) begin
                seg_cnt <= '0;
                r       <= '0;
            end else if (seg_cnt == len_cur - 5'd1) begin
                seg_cnt <= '0;
                r       <= (r == s_cur - 2'd1) ? 2'd0 : r + 2'd1;
            end else begin
                seg_cnt <= seg_cnt + 5'd1;
            end
            if (fill_done) begin
                g       <= '0;
                group_r <= r;
            end else begin
                g <= g + 2'd1;
            end
        end
    end

    // Output side: first bit comes straight from the completing write so it is valid next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q     <= 1'b0;
            dout_vld_q <= 1'b0;
            m          <= '0;
        end else if (fill_done) begin
            dout_q     <= buf_nxt[f_perm_idx(2'd0, r, s_cur)];
            dout_vld_q <= 1'b1;
            m          <= '0;
        end else if (drain_done) begin
            dout_vld_q <= 1'b0;
            m          <= '0;
        end else if (dout_acc) begin
            dout_q <= bit_buf[f_perm_idx(m + 2'd1, group_r, s_grp)];
            m      <= m + 2'd1;
        end
    end

endmodule

// File: tb/tb_deinterleaver_2.sv
// Self-checking bench for deinterleaver_2: directed vector table, backpressure, symbol
// boundary and reset corner cases, then randomized symbols against an index-formula model.
module tb_deinterleaver_2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din_vld;
    logic       din_rdy;
    logic       din_sig;
    logic [1:0] din_map;
    logic       dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic [1:0] dout_map;

    always #5 clk = ~clk;

    deinterleaver_2 dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .deintv2_din           (din),
        .deintv2_din_vld       (din_vld),
        .deintv2_din_rdy       (din_rdy),
        .deintv2_din_sig_flag  (din_sig),
        .deintv2_din_Map_Type  (din_map),
        .deintv2_dout          (dout),
        .deintv2_dout_vld      (dout_vld),
        .deintv2_dout_rdy      (dout_rdy),
        .deintv2_dout_Map_Type (dout_map)
    );

    typedef struct {
        logic       b;
        logic [1:0] mp;
    } exp_t;

    typedef struct {
        logic [1:0] map;
        logic       sig;
        int         jpos;
        int         n;
        logic [0:2] inb;
        logic [0:2] expb;
    } vec_t;

    exp_t  exp_q[$];
    logic  out_log[$];
    logic  sym_bits[288];
    vec_t  vecs[13];
    int    n_pass  = 0;
    int    n_total = 0;
    bit    rdy_rand = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    function automatic int tb_ncbps(input logic [1:0] mp);
        case (mp)
            2'b00:   return 48;
            2'b01:   return 96;
            2'b10:   return 192;
            default: return 288;
        endcase
    endfunction

    function automatic int tb_s(input logic [1:0] mp);
        if (mp == 2'b10) return 2;
        if (mp == 2'b11) return 3;
        return 1;
    endfunction

    // Output i takes the received bit at the transmit-side second-permutation index of i
    task automatic push_expected(input logic [1:0] me);
        int n, s, seg, jj;
        exp_t e;
        n = tb_ncbps(me);
        s = tb_s(me);
        for (int i = 0; i < n; i++) begin
            seg  = (16 * i) / n;
            jj   = s * (i / s) + (i + n - seg) % s;
            e.b  = sym_bits[jj];
            e.mp = me;
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        logic hold = 1'b0;
        logic held = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (hold) begin
                chk("hold_vld", int'(dout_vld), 1);
                chk("hold_dout", int'(dout), int'(held));
            end
            if (dout_vld && !dout_rdy) chk("drain_din_rdy", int'(din_rdy), 0);
            if (dout_vld && dout_rdy) begin
                chk("exp_available", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("dout_bit", int'(dout), int'(e.b));
                    chk("dout_map", int'(dout_map), int'(e.mp));
                end
                out_log.push_back(dout);
            end
            hold = rst_n && dout_vld && !dout_rdy;
            held = dout;
        end
    endtask

    task automatic rdy_driver();
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) dout_rdy = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic put_bit(input logic b, input logic [1:0] mp, input logic sg, input bit gap);
        bit ok = 1'b0;
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        din     = b;
        din_map = mp;
        din_sig = sg;
        din_vld = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (din_rdy) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        din_vld = 1'b0;
        chk("din_accept", int'(ok), 1);
    endtask

    task automatic run_symbol(input logic [1:0] mp, input logic sg, input bit gap,
                              input bit toggle, input bit lat_chk);
        logic [1:0] me;
        logic [1:0] m_drv;
        logic       s_drv;
        me = sg ? 2'b00 : mp;
        push_expected(me);
        for (int i = 0; i < tb_ncbps(me); i++) begin
            m_drv = (toggle && i > 0) ? 2'($urandom_range(0, 3)) : mp;
            s_drv = (toggle && i > 0) ? 1'($urandom_range(0, 1)) : sg;
            put_bit(sym_bits[i], m_drv, s_drv, gap);
            if (lat_chk) begin
                @(negedge clk);
                chk("latency_vld", int'(dout_vld), 1);
                chk("latency_dout", int'(dout), int'(sym_bits[i]));
            end
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic rand_bits();
        for (int i = 0; i < 288; i++) sym_bits[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [4:0] pat;
        logic       held;
        int         base;
        logic [1:0] mp;
        logic       sg;

        rst_n    = 1'b0;
        din      = 1'b0;
        din_vld  = 1'b0;
        din_sig  = 1'b0;
        din_map  = 2'b00;
        dout_rdy = 1'b1;

        vecs[0]  = '{2'b10, 1'b0, 0,   2, 3'b100, 3'b100};
        vecs[1]  = '{2'b10, 1'b0, 12,  2, 3'b100, 3'b010};
        vecs[2]  = '{2'b10, 1'b0, 36,  2, 3'b010, 3'b100};
        vecs[3]  = '{2'b10, 1'b0, 24,  2, 3'b010, 3'b010};
        vecs[4]  = '{2'b10, 1'b0, 180, 2, 3'b100, 3'b010};
        vecs[5]  = '{2'b11, 1'b0, 0,   3, 3'b100, 3'b100};
        vecs[6]  = '{2'b11, 1'b0, 18,  3, 3'b100, 3'b010};
        vecs[7]  = '{2'b11, 1'b0, 36,  3, 3'b100, 3'b001};
        vecs[8]  = '{2'b11, 1'b0, 21,  3, 3'b011, 3'b101};
        vecs[9]  = '{2'b11, 1'b0, 54,  3, 3'b011, 3'b011};
        vecs[10] = '{2'b11, 1'b0, 42,  3, 3'b110, 3'b101};
        vecs[11] = '{2'b01, 1'b0, 6,   2, 3'b100, 3'b100};
        vecs[12] = '{2'b11, 1'b1, 0,   3, 3'b100, 3'b100};

        fork
            monitor();
            rdy_driver();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_din_rdy", int'(din_rdy), 1);
        chk("rst_dout_vld", int'(dout_vld), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_map", int'(dout_map), 0);
        @(posedge clk);
        #1;

        // BPSK forced by sig_flag despite Map_Type=11; identity with one-cycle latency
        pat = 5'b10110;
        for (int i = 0; i < 48; i++) sym_bits[i] = pat[4 - (i % 5)];
        run_symbol(2'b11, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain();
        chk("bpsk_map", int'(dout_map), 0);

        foreach (vecs[v]) begin
            base = out_log.size();
            rand_bits();
            for (int k = 0; k < vecs[v].n; k++) sym_bits[vecs[v].jpos + k] = vecs[v].inb[k];
            run_symbol(vecs[v].map, vecs[v].sig, 1'b0, 1'b0, 1'b0);
            wait_drain();
            for (int k = 0; k < vecs[v].n; k++)
                chk($sformatf("vec%0d_bit%0d", v, k), int'(out_log[base + vecs[v].jpos + k]),
                    int'(vecs[v].expb[k]));
        end

        // Backpressure: stall dout_rdy for 5 cycles inside a 16QAM drain
        rand_bits();
        fork
            run_symbol(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
            begin
                repeat (40) @(posedge clk);
                for (int t = 0; t < 50; t++) begin
                    @(posedge clk);
                    #1;
                    if (dout_vld) break;
                end
                dout_rdy = 1'b0;
                held     = dout;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_din_rdy", int'(din_rdy), 0);
                    chk("bp_vld", int'(dout_vld), 1);
                    chk("bp_dout", int'(dout), int'(held));
                end
                @(posedge clk);
                #1;
                dout_rdy = 1'b1;
            end
        join
        wait_drain();

        // Symbol boundary with Map_Type/sig_flag toggling mid-symbol
        rand_bits();
        run_symbol(2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain();
        chk("bound_map_qpsk", int'(dout_map), 1);
        rand_bits();
        run_symbol(2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_drain();
        chk("bound_map_64qam", int'(dout_map), 3);

        // Reset after 2 of 3 bits of a 64QAM group, then a clean symbol
        put_bit(1'b1, 2'b11, 1'b0, 1'b0);
        put_bit(1'b0, 2'b11, 1'b0, 1'b0);
        chk("pre_rst_map", int'(dout_map), 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_din_rdy", int'(din_rdy), 1);
        chk("midrst_dout_vld", int'(dout_vld), 0);
        chk("midrst_map", int'(dout_map), 0);
        @(posedge clk);
        #1;
        rand_bits();
        run_symbol(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // Randomized symbols with random gaps, toggling and downstream stalls
        rdy_rand = 1'b1;
        for (int n = 0; n < 6; n++) begin
            rand_bits();
            mp = 2'($urandom_range(0, 3));
            sg = ($urandom_range(0, 4) == 0);
            run_symbol(mp, sg, 1'b1, 1'b1, 1'b0);
        end
        wait_drain();
        rdy_rand = 1'b0;
        dout_rdy = 1'b1;
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
